main_module: RTL and testbench

Streaming 3x3 neighbourhood generator for raster-scan 8-bit image data. Accepts one pixel per clock while `Start` is high, keeps the two previous image rows in internal line buffers and presents the current 3x3 window on nine byte outputs. Sits between the external frame memory reader and the downstream 3x3 filter/convolution datapath. Raises `Complete` once a full frame has been consumed.

---
 rtl/main_module.sv | 108 ++++++++++
 tb/tb_main_module.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/main_module.sv
// main_module: streaming 3x3 neighbourhood generator for raster-scan 8-bit pixels.
// Two line buffers delay the window rows by IMG_W-3 accepted pixels so that the
// nine window registers always hold the three most recent pixels of three
// consecutive image rows. Complete is sticky once the last frame pixel is taken.
// Optional feature macro: MAIN_MODULE_BORDER_ZERO_EN (zero left-border taps).
module main_module #(
    parameter int unsigned IMG_W = 256,
    parameter int unsigned IMG_H = 256
) (
    input  logic       CLK,
    input  logic       Reset,
    input  logic       Start,
    input  logic [7:0] dina,
    output logic [7:0] Out1,
    output logic [7:0] Out2,
    output logic [7:0] Out3,
    output logic [7:0] Out4,
    output logic [7:0] Out5,
    output logic [7:0] Out6,
    output logic [7:0] Out7,
    output logic [7:0] Out8,
    output logic [7:0] Out9,
    output logic       Complete
);

    localparam int unsigned LB_D = IMG_W - 3;
    localparam int unsigned LB_LAST = LB_D - 1;
    localparam int unsigned NPIX = IMG_W * IMG_H;
    localparam int unsigned PCW = $clog2(NPIX) + 1;
    localparam int unsigned CW = $clog2(IMG_W);

    logic [7:0]     r_w1, r_w2, r_w3, r_w4, r_w5, r_w6, r_w7, r_w8, r_w9;
    logic [7:0]     r_lb1 [LB_D];
    logic [7:0]     r_lb2 [LB_D];
    logic [CW-1:0]  r_col;
    logic [PCW-1:0] r_pix;
    logic           r_complete;
    logic           w_accept;

    // A pixel is consumed only while the frame is still open
    assign w_accept = Start && !r_complete;

    // Window shift, line buffers and frame counters
    always_ff @(posedge CLK) begin
        if (Reset) begin
            r_w1 <= 8'h00; r_w2 <= 8'h00; r_w3 <= 8'h00;
            r_w4 <= 8'h00; r_w5 <= 8'h00; r_w6 <= 8'h00;
            r_w7 <= 8'h00; r_w8 <= 8'h00; r_w9 <= 8'h00;
            for (int i = 0; i < LB_D; i++) begin
                r_lb1[i] <= 8'h00;
                r_lb2[i] <= 8'h00;
            end
            r_col      <= '0;
            r_pix      <= '0;
            r_complete <= 1'b0;
        end else if (w_accept) begin
            // bottom row: newest pixels
            r_w9 <= dina;
            r_w8 <= r_w9;
            r_w7 <= r_w8;
            // middle row fed from first line buffer
            r_w6 <= r_lb1[LB_LAST];
            r_w5 <= r_w6;
            r_w4 <= r_w5;
            // top row fed from second line buffer
            r_w3 <= r_lb2[LB_LAST];
            r_w2 <= r_w3;
            r_w1 <= r_w2;
            for (int i = LB_D - 1; i > 0; i--) begin
                r_lb1[i] <= r_lb1[i-1];
                r_lb2[i] <= r_lb2[i-1];
            end
            r_lb1[0] <= r_w7;
            r_lb2[0] <= r_w4;
            r_col <= (r_col == CW'(IMG_W - 1)) ? '0 : r_col + CW'(1);
            if (r_pix == PCW'(NPIX - 1)) begin
                r_complete <= 1'b1;
            end else begin
                r_pix <= r_pix + PCW'(1);
            end
        end
    end

`ifdef MAIN_MODULE_BORDER_ZERO_EN
    logic [CW-1:0] w_col9;

    // Column of the pixel currently shown on Out9 (r_col points at the next one)
    assign w_col9 = (r_col == '0) ? CW'(IMG_W - 1) : r_col - CW'(1);
`endif

    // Output taps, optionally masking taps that wrapped in from the previous row
    always_comb begin
        Out1 = r_w1; Out2 = r_w2; Out3 = r_w3;
        Out4 = r_w4; Out5 = r_w5; Out6 = r_w6;
        Out7 = r_w7; Out8 = r_w8; Out9 = r_w9;
        Complete = r_complete;
`ifdef MAIN_MODULE_BORDER_ZERO_EN
        if (w_col9 == '0) begin
            Out1 = 8'h00; Out2 = 8'h00;
            Out4 = 8'h00; Out5 = 8'h00;
            Out7 = 8'h00; Out8 = 8'h00;
        end else if (w_col9 == CW'(1)) begin
            Out1 = 8'h00; Out4 = 8'h00; Out7 = 8'h00;
        end
`endif
    end

endmodule

// File: tb/tb_main_module.sv
// Scoreboard bench for main_module: a small 4x4 instance and a default 256x256
// instance, both checked every cycle against a pixel-history reference model.
module tb_main_module;

    typedef struct {
        logic [71:0] win;
        logic        cmp;
    } exp_t;

    logic CLK = 1'b0;
    always #5 CLK = ~CLK;

    logic       rs, ss, rl, sl;
    logic [7:0] ds, dl;
    logic [7:0] so [9];
    logic [7:0] lo [9];
    logic       cs, cl;

    int nvec = 0;
    int nerr = 0;

    logic [7:0] hs [$];
    logic [7:0] hl [$];
    bit         done_s, done_l;
    exp_t       q_s [$];
    exp_t       q_l [$];

    main_module #(.IMG_W(4), .IMG_H(4)) dut_s (
        .CLK(CLK), .Reset(rs), .Start(ss), .dina(ds),
        .Out1(so[0]), .Out2(so[1]), .Out3(so[2]), .Out4(so[3]), .Out5(so[4]),
        .Out6(so[5]), .Out7(so[6]), .Out8(so[7]), .Out9(so[8]), .Complete(cs)
    );

    main_module dut_l (
        .CLK(CLK), .Reset(rl), .Start(sl), .dina(dl),
        .Out1(lo[0]), .Out2(lo[1]), .Out3(lo[2]), .Out4(lo[3]), .Out5(lo[4]),
        .Out6(lo[5]), .Out7(lo[6]), .Out8(lo[7]), .Out9(lo[8]), .Complete(cl)
    );

    function automatic logic [71:0] pack_win(input logic [7:0] o [9]);
        return {o[0], o[1], o[2], o[3], o[4], o[5], o[6], o[7], o[8]};
    endfunction

    // p[k] of the chosen stream, 0 for pixels not yet received
    function automatic logic [7:0] px(input bit big, input int k);
        if (k < 0) return 8'h00;
        return big ? hl[k] : hs[k];
    endfunction

    // Expected window from the accepted-pixel history
    function automatic logic [71:0] calc(input bit big);
        int w;
        int n;
        int off [9];
        logic [7:0] o [9];
        w = big ? 256 : 4;
        n = (big ? hl.size() : hs.size()) - 1;
        off = '{2*w+2, 2*w+1, 2*w, w+2, w+1, w, 2, 1, 0};
        for (int i = 0; i < 9; i++) o[i] = (n < 0) ? 8'h00 : px(big, n - off[i]);
`ifdef MAIN_MODULE_BORDER_ZERO_EN
        if (n >= 0) begin
            if (n % w == 0) begin
                o[0] = 0; o[1] = 0; o[3] = 0; o[4] = 0; o[6] = 0; o[7] = 0;
            end else if (n % w == 1) begin
                o[0] = 0; o[3] = 0; o[6] = 0;
            end
        end
`endif
        return {o[0], o[1], o[2], o[3], o[4], o[5], o[6], o[7], o[8]};
    endfunction

    // Advance both models by one clock edge using the inputs applied for it
    task automatic step();
        exp_t e;
        @(posedge CLK);
        if (rs) begin
            hs.delete(); done_s = 0;
        end else if (ss && !done_s) begin
            hs.push_back(ds);
            if (hs.size() == 16) done_s = 1;
        end
        if (rl) begin
            hl.delete(); done_l = 0;
        end else if (sl && !done_l) begin
            hl.push_back(dl);
            if (hl.size() == 65536) done_l = 1;
        end
        e.win = calc(0); e.cmp = done_s; q_s.push_back(e);
        e.win = calc(1); e.cmp = done_l; q_l.push_back(e);
        #1;
    endtask

    task automatic chk(input string name, input logic [71:0] got, input logic [71:0] exp);
        nvec++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    // Monitor: compare both DUTs against the queued expectations each cycle
    initial begin
        exp_t e;
        forever begin
            @(negedge CLK);
            if (q_s.size() > 0) begin
                e = q_s.pop_front();
                chk("small_window", pack_win(so), e.win);
                chk("small_complete", 72'(cs), 72'(e.cmp));
            end
            if (q_l.size() > 0) begin
                e = q_l.pop_front();
                chk("large_window", pack_win(lo), e.win);
                chk("large_complete", 72'(cl), 72'(e.cmp));
            end
        end
    end

    initial begin
        logic [7:0] last;
        rs = 1; ss = 1; ds = 8'h55; rl = 1; sl = 0; dl = 8'h00;
        done_s = 0; done_l = 0;
        #2;
        // reset with Start high: pixel discarded
        step();
        chk("reset_window", pack_win(so), 72'h0);
        chk("reset_complete", 72'(cs), 72'h0);
        rs = 0;
        // ramp 01..10 into the 4x4 instance
        for (int i = 1; i <= 16; i++) begin
            ss = 1; ds = 8'(i);
            step();
            if (i == 1) chk("first_pixel", pack_win(so), 72'h01);
`ifdef MAIN_MODULE_BORDER_ZERO_EN
            if (i == 9) chk("ramp_px09", pack_win(so), 72'h000001_000005_000009);
`else
            if (i == 9) chk("ramp_px09", pack_win(so), 72'h000001_030405_070809);
`endif
            if (i == 11) chk("ramp_px0b", pack_win(so), 72'h010203_050607_090A0B);
            if (i == 15) chk("pre_complete", 72'(cs), 72'h0);
        end
        chk("complete_rise", 72'(cs), 72'h1);
        for (int i = 0; i < 10; i++) begin
            ds = 8'($urandom); step();
        end
        chk("frozen_out9", 72'(so[8]), 72'h10);
        chk("complete_sticky", 72'(cs), 72'h1);
        // stall for five cycles mid-frame
        rs = 1; step(); rs = 0;
        for (int i = 0; i < 9; i++) begin
            if (i == 4) begin
                for (int j = 0; j < 5; j++) begin
                    ss = 0; ds = 8'($urandom); step();
                end
            end
            ss = 1; ds = 8'(8'h30 + i); step();
        end
        // reset after seven pixels, then new ramp from A0
        rs = 1; step(); rs = 0;
        for (int i = 0; i < 7; i++) begin
            ss = 1; ds = 8'(8'h70 + i); step();
        end
        rs = 1; step(); rs = 0;
        chk("midreset_window", pack_win(so), 72'h0);
        for (int i = 0; i < 12; i++) begin
            ss = 1; ds = 8'(8'hA0 + i); step();
            if (i == 0) chk("restart_pixel0", pack_win(so), 72'hA0);
        end
        // randomized traffic with occasional resets
        for (int i = 0; i < 400; i++) begin
            rs = (done_s && $urandom_range(0, 7) == 0) || ($urandom_range(0, 99) == 0);
            ss = ($urandom_range(0, 3) != 0);
            ds = 8'($urandom);
            step();
        end
        rs = 0; ss = 0;
        // full default-size frame
        rl = 1; step(); rl = 0;
        last = 8'h00;
        for (int i = 0; i < 65536; i++) begin
            if (i == 1000) begin
                for (int j = 0; j < 3; j++) begin
                    sl = 0; dl = 8'($urandom); step();
                end
            end
            sl = 1; dl = 8'($urandom); last = dl;
            step();
            if (i == 65534) chk("large_pre_complete", 72'(cl), 72'h0);
        end
        chk("large_complete_rise", 72'(cl), 72'h1);
        chk("large_last_out9", 72'(lo[8]), 72'(last));
        for (int i = 0; i < 10; i++) begin
            dl = 8'($urandom); step();
        end
        chk("large_frozen_out9", 72'(lo[8]), 72'(last));
        chk("large_complete_sticky", 72'(cl), 72'h1);
        sl = 0;
        for (int i = 0; i < 4 && (q_s.size() > 0 || q_l.size() > 0); i++) @(negedge CLK);
        #1;
        if (q_s.size() > 0 || q_l.size() > 0) begin
            nvec++; nerr++;
            $display("FAIL drain: %0d/%0d expectations left, required 0", q_s.size(), q_l.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
